// File: rtl/vga_grid_pkg.sv
// Shared constants and helpers for the VGA raster / cell-grid timing block.
// Defaults describe standard 640x480@60 timing.
package vga_grid_pkg;

    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;

    // Asserted level of hsync/vsync.
    typedef enum logic {
        SyncNeg = 1'b0,
        SyncPos = 1'b1
    } sync_pol_e;

    function automatic int unsigned h_total(input int unsigned sync, input int unsigned back,
                                            input int unsigned vis, input int unsigned front);
        return sync + back + vis + front;
    endfunction

    function automatic int unsigned v_total(input int unsigned sync, input int unsigned back,
                                            input int unsigned vis, input int unsigned front);
        return sync + back + vis + front;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_grid_timing_if.sv
// Output bundle of vga_grid_timing: sync, blanking, coordinates and cell mapping.
interface vga_grid_timing_if
    import vga_grid_pkg::*;
#(
    parameter int unsigned HC_W  = cnt_w(h_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_VISIBLE,
                                                 DEF_H_FRONT)),
    parameter int unsigned VC_W  = cnt_w(v_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_VISIBLE,
                                                 DEF_V_FRONT)),
    parameter int unsigned COL_W = 4,
    parameter int unsigned ROW_W = 4,
    parameter int unsigned CX_W  = 5,
    parameter int unsigned CY_W  = 5
);
    logic             pix_en;
    logic             hsync;
    logic             vsync;
    logic [HC_W-1:0]  hc;
    logic [VC_W-1:0]  vc;
    logic             active;
    logic             in_grid;
    logic             bright;
    logic [COL_W-1:0] cell_col;
    logic [ROW_W-1:0] cell_row;
    logic [CX_W-1:0]  cell_x;
    logic [CY_W-1:0]  cell_y;
    logic             line_start;
    logic             frame_start;

    modport master (
        output pix_en, hsync, vsync, hc, vc, active, in_grid, bright,
               cell_col, cell_row, cell_x, cell_y, line_start, frame_start
    );

    modport slave (
        input pix_en, hsync, vsync, hc, vc, active, in_grid, bright,
              cell_col, cell_row, cell_x, cell_y, line_start, frame_start
    );
endinterface

// File: rtl/pixel_tick_gen.sv
// Pixel clock-enable divider: pix_en is high for one clk every CLK_DIV clks.
module pixel_tick_gen
    import vga_grid_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);
    localparam int unsigned DW = cnt_w(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign pix_en = (div_q == DIV_LAST);
endmodule

// File: rtl/vga_grid_timing.sv
// VGA raster timing with cell-grid mapping; all outputs except pix_en registered per tick.
// Define GRID_LINES_EN to blank the left/top LINE_W pixels of every cell.
module vga_grid_timing
    import vga_grid_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter sync_pol_e   SYNC_POL  = SyncNeg,
    parameter int unsigned GRID_COLS = 16,
    parameter int unsigned GRID_ROWS = 16,
    parameter int unsigned CELL_W    = 30,
    parameter int unsigned CELL_H    = 30,
    parameter int unsigned GRID_X0   = 80,
    parameter int unsigned GRID_Y0   = 0,
    parameter int unsigned LINE_W    = 2
) (
    input logic               clk,
    input logic               rst_n,
    vga_grid_timing_if.master vif
);
    localparam int unsigned H_TOTAL = h_total(H_SYNC, H_BACK, H_VISIBLE, H_FRONT);
    localparam int unsigned V_TOTAL = v_total(V_SYNC, V_BACK, V_VISIBLE, V_FRONT);
    localparam int unsigned HW = cnt_w(H_TOTAL);
    localparam int unsigned VW = cnt_w(V_TOTAL);
    localparam int unsigned COLW = cnt_w(GRID_COLS);
    localparam int unsigned ROWW = cnt_w(GRID_ROWS);
    localparam int unsigned CXW = cnt_w(CELL_W);
    localparam int unsigned CYW = cnt_w(CELL_H);
    localparam int unsigned HA = H_SYNC + H_BACK;
    localparam int unsigned VA = V_SYNC + V_BACK;

    // One extra bit so segment ends equal to the total still compare correctly.
    localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_SYNC);
    localparam logic [HW:0] H_ACT_BEG  = (HW+1)'(HA);
    localparam logic [HW:0] H_ACT_END  = (HW+1)'(HA + H_VISIBLE);
    localparam logic [HW:0] H_GRID_BEG = (HW+1)'(HA + GRID_X0);
    localparam logic [HW:0] H_GRID_END = (HW+1)'(HA + GRID_X0 + GRID_COLS * CELL_W);
    localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_SYNC);
    localparam logic [VW:0] V_ACT_BEG  = (VW+1)'(VA);
    localparam logic [VW:0] V_ACT_END  = (VW+1)'(VA + V_VISIBLE);
    localparam logic [VW:0] V_GRID_BEG = (VW+1)'(VA + GRID_Y0);
    localparam logic [VW:0] V_GRID_END = (VW+1)'(VA + GRID_Y0 + GRID_ROWS * CELL_H);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [CXW-1:0] CX_LAST = CXW'(CELL_W - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(CELL_H - 1);
    localparam logic SYNC_ON  = logic'(SYNC_POL);
    localparam logic SYNC_OFF = ~SYNC_ON;

    if (CLK_DIV < 1) begin : g_err_div
        $error("CLK_DIV must be at least 1");
    end
    if (GRID_X0 + GRID_COLS * CELL_W > H_VISIBLE) begin : g_err_grid_x
        $error("grid does not fit in the visible width");
    end
    if (GRID_Y0 + GRID_ROWS * CELL_H > V_VISIBLE) begin : g_err_grid_y
        $error("grid does not fit in the visible height");
    end
    if (LINE_W >= CELL_W || LINE_W >= CELL_H) begin : g_err_line_w
        $error("LINE_W must be smaller than the cell size");
    end

    logic            pix_en;
    logic [HW-1:0]   hcnt_q;
    logic [VW-1:0]   vcnt_q;
    logic [COLW-1:0] col_q;
    logic [ROWW-1:0] row_q;
    logic [CXW-1:0]  cx_q;
    logic [CYW-1:0]  cy_q;

    logic            hsync_q, vsync_q, active_q, in_grid_q, bright_q;
    logic            line_start_q, frame_start_q;
    logic [HW-1:0]   hc_q;
    logic [VW-1:0]   vc_q;
    logic [COLW-1:0] cell_col_q;
    logic [ROWW-1:0] cell_row_q;
    logic [CXW-1:0]  cell_x_q;
    logic [CYW-1:0]  cell_y_q;

    logic [HW:0] hx;
    logic [VW:0] vy;
    logic        h_act, v_act, h_grid, v_grid, in_grid_c, bright_c, line_end, frame_end;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .pix_en(pix_en)
    );

    always_comb begin
        hx        = {1'b0, hcnt_q};
        vy        = {1'b0, vcnt_q};
        h_act     = (hx >= H_ACT_BEG) && (hx < H_ACT_END);
        v_act     = (vy >= V_ACT_BEG) && (vy < V_ACT_END);
        h_grid    = (hx >= H_GRID_BEG) && (hx < H_GRID_END);
        v_grid    = (vy >= V_GRID_BEG) && (vy < V_GRID_END);
        in_grid_c = h_grid && v_grid;
        line_end  = (hcnt_q == H_LAST);
        frame_end = line_end && (vcnt_q == V_LAST);
`ifdef GRID_LINES_EN
        bright_c  = in_grid_c && (cx_q >= CXW'(LINE_W)) && (cy_q >= CYW'(LINE_W));
`else
        bright_c  = in_grid_c;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            hc_q          <= '0;
            vc_q          <= '0;
            active_q      <= 1'b0;
            in_grid_q     <= 1'b0;
            bright_q      <= 1'b0;
            cell_col_q    <= '0;
            cell_row_q    <= '0;
            cell_x_q      <= '0;
            cell_y_q      <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            hcnt_q <= line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end

            // Cell counters track the pixel currently held in hcnt_q/vcnt_q.
            if (line_end) begin
                cx_q  <= '0;
                col_q <= '0;
            end else if (h_grid) begin
                cx_q  <= (cx_q == CX_LAST) ? '0 : cx_q + 1'b1;
                col_q <= (cx_q == CX_LAST) ? col_q + 1'b1 : col_q;
            end
            if (frame_end) begin
                cy_q  <= '0;
                row_q <= '0;
            end else if (line_end && v_grid) begin
                cy_q  <= (cy_q == CY_LAST) ? '0 : cy_q + 1'b1;
                row_q <= (cy_q == CY_LAST) ? row_q + 1'b1 : row_q;
            end

            hsync_q       <= (hx < H_SYNC_END) ? SYNC_ON : SYNC_OFF;
            vsync_q       <= (vy < V_SYNC_END) ? SYNC_ON : SYNC_OFF;
            hc_q          <= hcnt_q;
            vc_q          <= vcnt_q;
            active_q      <= h_act && v_act;
            in_grid_q     <= in_grid_c;
            bright_q      <= bright_c;
            cell_col_q    <= in_grid_c ? col_q : '0;
            cell_row_q    <= in_grid_c ? row_q : '0;
            cell_x_q      <= in_grid_c ? cx_q : '0;
            cell_y_q      <= in_grid_c ? cy_q : '0;
            line_start_q  <= (hcnt_q == '0);
            frame_start_q <= (hcnt_q == '0) && (vcnt_q == '0);
        end
    end

    assign vif.pix_en      = pix_en;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.hc          = hc_q;
    assign vif.vc          = vc_q;
    assign vif.active      = active_q;
    assign vif.in_grid     = in_grid_q;
    assign vif.bright      = bright_q;
    assign vif.cell_col    = cell_col_q;
    assign vif.cell_row    = cell_row_q;
    assign vif.cell_x      = cell_x_q;
    assign vif.cell_y      = cell_y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_grid_timing.sv
// Bench for vga_grid_timing on a reduced raster so whole frames fit in a short run.
module tb_vga_grid_timing;
    import vga_grid_pkg::*;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned HS = 4, HB = 3, HV = 40, HF = 3;
    localparam int unsigned VS = 2, VB = 3, VV = 24, VF = 2;
    localparam int unsigned COLS = 5, ROWS = 4, CW = 6, CH = 5, GX0 = 6, GY0 = 2, LW = 2;
    localparam int unsigned HT = h_total(HS, HB, HV, HF);
    localparam int unsigned VT = v_total(VS, VB, VV, VF);
    localparam int unsigned FRAME = HT * VT;
    localparam bit POL = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mh = 0;
    int   mv = 0;

    vga_grid_timing_if #(
        .HC_W (cnt_w(HT)),
        .VC_W (cnt_w(VT)),
        .COL_W(cnt_w(COLS)),
        .ROW_W(cnt_w(ROWS)),
        .CX_W (cnt_w(CW)),
        .CY_W (cnt_w(CH))
    ) vif ();

    vga_grid_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_SYNC   (HS),
        .H_BACK   (HB),
        .H_VISIBLE(HV),
        .H_FRONT  (HF),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .V_VISIBLE(VV),
        .V_FRONT  (VF),
        .SYNC_POL (SyncNeg),
        .GRID_COLS(COLS),
        .GRID_ROWS(ROWS),
        .CELL_W   (CW),
        .CELL_H   (CH),
        .GRID_X0  (GX0),
        .GRID_Y0  (GY0),
        .LINE_W   (LW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vif  (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at model pixel (%0d,%0d): got %0d expected %0d", tag, mh, mv, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_pix_en", 32'(vif.pix_en), 32'(0));
        chk("rst_hsync", 32'(vif.hsync), 32'(!POL));
        chk("rst_vsync", 32'(vif.vsync), 32'(!POL));
        chk("rst_hc", 32'(vif.hc), 32'(0));
        chk("rst_vc", 32'(vif.vc), 32'(0));
        chk("rst_active", 32'(vif.active), 32'(0));
        chk("rst_in_grid", 32'(vif.in_grid), 32'(0));
        chk("rst_bright", 32'(vif.bright), 32'(0));
        chk("rst_cells", 32'({vif.cell_col, vif.cell_row, vif.cell_x, vif.cell_y}), 32'(0));
        chk("rst_markers", 32'({vif.line_start, vif.frame_start}), 32'(0));
    endtask

    // Expected outputs for pixel (h,v), straight from the raster/grid geometry.
    task automatic check_pixel(input int h, input int v);
        int x, y, gx, gy, col, row, cx, cy;
        bit act, ing, br;
        x   = h - int'(HS + HB);
        y   = v - int'(VS + VB);
        act = (x >= 0) && (x < int'(HV)) && (y >= 0) && (y < int'(VV));
        gx  = x - int'(GX0);
        gy  = y - int'(GY0);
        ing = act && (gx >= 0) && (gx < int'(COLS * CW)) && (gy >= 0) && (gy < int'(ROWS * CH));
        col = ing ? gx / int'(CW) : 0;
        cx  = ing ? gx % int'(CW) : 0;
        row = ing ? gy / int'(CH) : 0;
        cy  = ing ? gy % int'(CH) : 0;
`ifdef GRID_LINES_EN
        br  = ing && (cx >= int'(LW)) && (cy >= int'(LW));
`else
        br  = ing;
`endif
        chk("hc", 32'(vif.hc), 32'(h));
        chk("vc", 32'(vif.vc), 32'(v));
        chk("hsync", 32'(vif.hsync), 32'((h < int'(HS)) ? POL : !POL));
        chk("vsync", 32'(vif.vsync), 32'((v < int'(VS)) ? POL : !POL));
        chk("active", 32'(vif.active), 32'(act));
        chk("in_grid", 32'(vif.in_grid), 32'(ing));
        chk("bright", 32'(vif.bright), 32'(br));
        chk("cell_col", 32'(vif.cell_col), 32'(col));
        chk("cell_row", 32'(vif.cell_row), 32'(row));
        chk("cell_x", 32'(vif.cell_x), 32'(cx));
        chk("cell_y", 32'(vif.cell_y), 32'(cy));
        chk("line_start", 32'(vif.line_start), 32'(h == 0));
        chk("frame_start", 32'(vif.frame_start), 32'(h == 0 && v == 0));
    endtask

    // Wait for the next pix_en, then sample just after the edge that registers it.
    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (vif.pix_en !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("tick_timeout", 32'(n < 16), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            check_pixel(mh, mv);
            mh++;
            if (mh == int'(HT)) begin
                mh = 0;
                mv = (mv == int'(VT) - 1) ? 0 : mv + 1;
            end
        end
    endtask

    initial begin
        int hold;
        int stop_at;

        repeat (3) begin
            @(negedge clk);
            check_reset();
        end

        // Divider phase right after release.
        rst_n = 1'b1;
        for (int k = 0; k < 3 * int'(CLK_DIV); k++) begin
            #1;
            chk("pix_en_phase", 32'(vif.pix_en), 32'((k % int'(CLK_DIV)) == int'(CLK_DIV) - 1));
            @(negedge clk);
        end

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset();
        hold = int'($urandom_range(1, 4));
        repeat (hold) begin
            @(negedge clk);
            check_reset();
        end
        rst_n = 1'b1;
        mh = 0;
        mv = 0;
        run_ticks(2 * int'(FRAME) + int'(HT) + 7);

        // Asynchronous reset at a random point inside the frame.
        stop_at = int'($urandom_range(3 * HT, FRAME - HT));
        run_ticks(stop_at);
        #2 rst_n = 1'b0;
        #1 check_reset();
        hold = int'($urandom_range(1, 5));
        repeat (hold) begin
            @(negedge clk);
            check_reset();
        end
        rst_n = 1'b1;
        mh = 0;
        mv = 0;
        run_ticks(int'(FRAME) + int'(HT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
